dds_axis_packetizer: RTL and testbench
======================================

// Module: dds_axis_packetizer
// PURPOSE
// - Consumes the DDS sample stream (signal + one-cycle valid strobe, no backpressure) and emits AXI4-Stream.
// - Buffers samples in a small FIFO, frames them into packets of i_pkt_len beats with tlast, and flags drops.
// - Sits directly downstream of the DDS/clock-divider top, upstream of DMA or AXIS interconnect.
// PARAMETERS
// - SIG_WIDTH   16  sample / tdata width
// - FIFO_DEPTH  16  sample buffer entries; power of two, >= 2
// - PKT_LEN_W   16  width of packet-length input
// PORTS
// - clk             in   1               single clock for all logic
// - a_rst_n         in   1               asynchronous, active-low reset
// - i_pkt_en        in   1               framing enable (from control register)
// - i_pkt_len       in   PKT_LEN_W       beats per packet; 0 treated as 1
// - i_sample        in   SIG_WIDTH       DDS sample
// - i_sample_valid  in   1               DDS sample strobe; not back-pressurable
// - o_tdata         out  SIG_WIDTH       AXIS data
// - o_tvalid        out  1               AXIS valid
// - i_tready        in   1               AXIS ready
// - o_tlast         out  1               last beat of packet
// - o_ovf           out  1               sticky: sample dropped on full FIFO
// - i_ovf_clr       in   1               clear o_ovf (one-cycle pulse)
// - o_level         out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
// - Reset: FIFO empty, state IDLE, beat count 0, o_tvalid/o_tlast/o_ovf = 0, o_tdata = 0, o_level = 0.
// - FSM IDLE -> RUN when i_pkt_en = 1; latch len = max(i_pkt_len,1), beat_cnt = 0.
// - RUN: push when i_sample_valid && !full; full is judged on registered count (no same-cycle pop bypass).
// - RUN: push when full -> sample dropped, o_ovf <= 1. Simultaneous set and i_ovf_clr: set wins.
// - Output is show-ahead: o_tvalid = !empty; a sample pushed at edge N is on o_tdata after edge N.
// - Beat accepted on o_tvalid && i_tready: pop, beat_cnt++. o_tlast = (beat_cnt == len-1).
// - On the tlast beat: beat_cnt <= 0 and len re-latched from i_pkt_len (new length applies per packet only).
// - RUN -> DRAIN when i_pkt_en falls. DRAIN: no pushes. Pops continue; if FIFO empties before tlast,
//   emit zero-data pad beats (o_tvalid=1, o_tdata=0) until the tlast beat is accepted.
// - DRAIN -> IDLE after tlast beat accepted. If beat_cnt = 0 and FIFO empty when i_pkt_en falls, go to IDLE.
// - Leftover FIFO entries after tlast in DRAIN are flushed (discarded) on entering IDLE.
// - AXIS rule: once o_tvalid = 1, o_tdata/o_tlast are held until i_tready; o_tvalid never drops without a handshake.
// - Pointers wrap modulo FIFO_DEPTH; count saturates at FIFO_DEPTH; push+pop same cycle keeps count.
// - Reset mid-packet: everything returns to reset values immediately; no partial-packet completion.
// CONFIGURATION
// - DDS_PKT_TUSER_EN defined: adds output o_tuser (1 bit) = 1 on the first beat of every packet (beat_cnt == 0),
//   held with o_tdata; reset 0.
// - Not defined: port o_tuser absent; no SOF logic.
// STRUCTURE
// - dds_pkg: typedef enum {IDLE, RUN, DRAIN} pkt_state_t; SIG_WIDTH default constant; clog2-based level width.
// - Sub-module dds_sample_fifo: synchronous show-ahead FIFO (push/pop/full/empty/level/flush).
// - Top holds FSM, beat counter, length latch, pad mux, overflow flag.
// TESTING
// - len=4, i_tready=1, 8 strobes 1..8 -> beats 1..8, o_tlast on values 4 and 8, o_ovf=0.
// - i_tready=0, 20 strobes, DEPTH=16 -> o_level=16, 4 drops, o_ovf=1; i_ovf_clr -> o_ovf=0.
// - len=5, 3 samples then i_pkt_en=0 -> beats s1,s2,s3,0,0 with tlast on 5th, state IDLE afterwards.
// - i_pkt_len 4 -> 2 changed mid-packet -> current packet still 4 beats, next packets 2 beats.
// - Random i_tready stalls -> o_tdata/o_tlast stable while o_tvalid && !i_tready; no loss when not full.
// - a_rst_n asserted mid-packet -> all outputs 0 same cycle; restart yields fresh packet from beat 0.

Source files
------------

// File: rtl/dds_axis_packetizer_pkg.sv
// dds_pkg: shared types and constants for the DDS sample packetizer.
package dds_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} pkt_state_t;
  localparam int DDS_SIG_WIDTH = 16;
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/dds_axis_packetizer_if.sv
// dds_axis_packetizer_if: AXI4-Stream output bus; o_tuser exists only with DDS_PKT_TUSER_EN.
interface dds_axis_packetizer_if #(parameter int W = 16);
  logic [W-1:0] o_tdata;
  logic o_tvalid;
  logic i_tready;
  logic o_tlast;
`ifdef DDS_PKT_TUSER_EN
  logic o_tuser;
  modport master (output o_tdata, o_tvalid, o_tlast, o_tuser, input i_tready);
  modport slave (input o_tdata, o_tvalid, o_tlast, o_tuser, output i_tready);
`else
  modport master (output o_tdata, o_tvalid, o_tlast, input i_tready);
  modport slave (input o_tdata, o_tvalid, o_tlast, output i_tready);
`endif
endinterface

// File: rtl/dds_axis_packetizer_fifo.sv
// dds_sample_fifo: show-ahead sample FIFO with occupancy and synchronous flush.
module dds_sample_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic a_rst_n,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign level = count;
  assign dout = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/dds_axis_packetizer.sv
// dds_axis_packetizer: frames the DDS sample stream into AXI4-Stream packets with drop flag.
// Optional macro DDS_PKT_TUSER_EN adds o_tuser marking the first beat of each packet.
module dds_axis_packetizer
  import dds_pkg::*;
#(
  parameter int SIG_WIDTH = DDS_SIG_WIDTH,
  parameter int FIFO_DEPTH = 16,
  parameter int PKT_LEN_W = 16
) (
  input  logic clk,
  input  logic a_rst_n,
  input  logic i_pkt_en,
  input  logic [PKT_LEN_W-1:0] i_pkt_len,
  input  logic [SIG_WIDTH-1:0] i_sample,
  input  logic i_sample_valid,
  input  logic i_ovf_clr,
  output logic o_ovf,
  output logic [lvl_w(FIFO_DEPTH)-1:0] o_level,
  dds_axis_packetizer_if.master axis
);
  pkt_state_t state;
  logic [PKT_LEN_W-1:0] len, beat_cnt, len_in;
  logic [SIG_WIDTH-1:0] fifo_data;
  logic full, empty, pad, tvalid, hs, last, push, pop, flush;
  dds_sample_fifo #(.W(SIG_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk, .a_rst_n, .push, .pop, .flush,
    .din(i_sample), .dout(fifo_data), .full, .empty, .level(o_level)
  );
  assign len_in = i_pkt_len == '0 ? PKT_LEN_W'(1) : i_pkt_len;
  // Pad only inside a started packet, so a drained-empty FIFO never raises a valid it can't hold.
  assign pad = state == DRAIN && empty && beat_cnt != '0;
  assign tvalid = !empty || pad;
  assign hs = tvalid && axis.i_tready;
  assign last = beat_cnt == len - 1'b1;
  assign push = state == RUN && i_sample_valid;
  assign pop = hs && !empty;
  assign flush = state == DRAIN && hs && last;
  assign axis.o_tvalid = tvalid;
  assign axis.o_tdata = empty ? '0 : fifo_data;
  assign axis.o_tlast = tvalid && last;
`ifdef DDS_PKT_TUSER_EN
  assign axis.o_tuser = tvalid && beat_cnt == '0;
`endif
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state <= IDLE;
      len <= PKT_LEN_W'(1);
      beat_cnt <= '0;
      o_ovf <= 1'b0;
    end else begin
      o_ovf <= (push && full) ? 1'b1 : (i_ovf_clr ? 1'b0 : o_ovf);
      if (hs) begin
        beat_cnt <= last ? '0 : beat_cnt + 1'b1;
        if (last) len <= len_in;
      end
      case (state)
        IDLE: if (i_pkt_en) begin
          state <= RUN;
          len <= len_in;
          beat_cnt <= '0;
        end
        RUN: if (!i_pkt_en) state <= (beat_cnt == '0 && empty) ? IDLE : DRAIN;
        DRAIN: if ((hs && last) || (beat_cnt == '0 && empty)) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dds_axis_packetizer.sv
// tb_dds_axis_packetizer: directed checks of framing, overflow, drain padding, stalls and reset.
module tb_dds_axis_packetizer;
  import dds_pkg::*;
  logic clk = 0, a_rst_n = 0, i_pkt_en = 0, i_sample_valid = 0, i_ovf_clr = 0, o_ovf;
  logic [15:0] i_pkt_len = 16'd4, i_sample = '0;
  logic [4:0] o_level;
  int n_cmp = 0, n_bad = 0;
  logic [16:0] q[$];
  logic stalled = 0, pl = 0;
  logic [15:0] pd = '0;
  dds_axis_packetizer_if #(.W(16)) axis ();
  dds_axis_packetizer dut (
    .clk(clk), .a_rst_n(a_rst_n), .i_pkt_en(i_pkt_en), .i_pkt_len(i_pkt_len),
    .i_sample(i_sample), .i_sample_valid(i_sample_valid), .i_ovf_clr(i_ovf_clr),
    .o_ovf(o_ovf), .o_level(o_level), .axis(axis)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_q(input string tag, input int idx, input logic [15:0] d, input logic l);
    chk(tag, idx < q.size() ? {15'd0, q[idx]} : 32'hdead_beef, {15'd0, l, d});
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic strobe(input logic [15:0] v);
    i_sample = v;
    i_sample_valid = 1;
    tick();
    i_sample_valid = 0;
  endtask
  // Beat collector plus AXIS hold-while-stalled checks.
  always @(negedge clk) begin
    if (!a_rst_n) stalled = 0;
    else begin
      if (stalled) begin
        chk("hold_valid", {31'd0, axis.o_tvalid}, 32'd1);
        chk("hold_data", {16'd0, axis.o_tdata}, {16'd0, pd});
        chk("hold_last", {31'd0, axis.o_tlast}, {31'd0, pl});
      end
      stalled = axis.o_tvalid && !axis.i_tready;
      pd = axis.o_tdata;
      pl = axis.o_tlast;
      if (axis.o_tvalid && axis.i_tready) q.push_back({axis.o_tlast, axis.o_tdata});
    end
  end
  initial begin
    axis.i_tready = 1;
    repeat (2) tick();
    chk("rst_valid", {31'd0, axis.o_tvalid}, 0);
    chk("rst_last", {31'd0, axis.o_tlast}, 0);
    chk("rst_data", {16'd0, axis.o_tdata}, 0);
    chk("rst_ovf", {31'd0, o_ovf}, 0);
    chk("rst_level", {27'd0, o_level}, 0);
    a_rst_n = 1;
    // basic framing, len 4
    i_pkt_en = 1;
    tick();
    for (int i = 1; i <= 8; i++) strobe(16'(i));
    repeat (5) tick();
    chk("t1_count", q.size(), 8);
    for (int i = 0; i < 8; i++) chk_q("t1_beat", i, 16'(i + 1), (i % 4) == 3);
    chk("t1_ovf", {31'd0, o_ovf}, 0);
    // overflow with output stalled
    axis.i_tready = 0;
    for (int i = 1; i <= 20; i++) strobe(16'(100 + i));
    chk("t2_level", {27'd0, o_level}, 16);
    chk("t2_ovf", {31'd0, o_ovf}, 1);
    chk("t2_head", {16'd0, axis.o_tdata}, 101);
    i_ovf_clr = 1;
    tick();
    i_ovf_clr = 0;
    chk("t2_ovf_clr", {31'd0, o_ovf}, 0);
    q.delete();
    axis.i_tready = 1;
    repeat (20) tick();
    chk("t2_count", q.size(), 16);
    chk_q("t2_first", 0, 101, 0);
    chk_q("t2_b3", 3, 104, 1);
    chk_q("t2_b15", 15, 116, 1);
    chk("t2_level_end", {27'd0, o_level}, 0);
    i_pkt_en = 0;
    repeat (2) tick();
    // early stop pads to length 5
    q.delete();
    i_pkt_len = 5;
    i_pkt_en = 1;
    tick();
    strobe(11);
    strobe(12);
    strobe(13);
    i_pkt_en = 0;
    repeat (10) tick();
    chk("t3_count", q.size(), 5);
    chk_q("t3_b0", 0, 11, 0);
    chk_q("t3_b1", 1, 12, 0);
    chk_q("t3_b2", 2, 13, 0);
    chk_q("t3_b3", 3, 0, 0);
    chk_q("t3_b4", 4, 0, 1);
    chk("t3_state", {30'd0, dut.state}, {30'd0, IDLE});
    chk("t3_valid", {31'd0, axis.o_tvalid}, 0);
    // length change mid packet
    q.delete();
    i_pkt_len = 4;
    i_pkt_en = 1;
    tick();
    strobe(201);
    i_pkt_len = 2;
    for (int i = 2; i <= 8; i++) strobe(16'(200 + i));
    repeat (4) tick();
    chk("t4_count", q.size(), 8);
    for (int i = 0; i < 8; i++) chk_q("t4_beat", i, 16'(201 + i), i == 3 || i == 5 || i == 7);
    i_pkt_en = 0;
    repeat (3) tick();
    // random ready stalls, len 3
    q.delete();
    i_pkt_len = 3;
    i_pkt_en = 1;
    tick();
    for (int i = 0; i < 12; i++) begin
      axis.i_tready = 1'($urandom_range(0, 1));
      strobe(16'(51 + i));
      axis.i_tready = 1'($urandom_range(0, 1));
      tick();
    end
    axis.i_tready = 1;
    repeat (20) tick();
    chk("t5_count", q.size(), 12);
    for (int i = 0; i < 12; i++) chk_q("t5_beat", i, 16'(51 + i), (i % 3) == 2);
    i_pkt_en = 0;
    repeat (3) tick();
    // asynchronous reset mid packet
    i_pkt_len = 4;
    i_pkt_en = 1;
    tick();
    axis.i_tready = 0;
    strobe(301);
    strobe(302);
    chk("t6_pre_valid", {31'd0, axis.o_tvalid}, 1);
    a_rst_n = 0;
    #1;
    chk("t6_valid", {31'd0, axis.o_tvalid}, 0);
    chk("t6_last", {31'd0, axis.o_tlast}, 0);
    chk("t6_data", {16'd0, axis.o_tdata}, 0);
    chk("t6_level", {27'd0, o_level}, 0);
    tick();
    a_rst_n = 1;
    q.delete();
    tick();
    axis.i_tready = 1;
    for (int i = 1; i <= 4; i++) strobe(16'(400 + i));
    repeat (4) tick();
    chk("t6_count", q.size(), 4);
    for (int i = 0; i < 4; i++) chk_q("t6_beat", i, 16'(401 + i), i == 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
